button_conditioner: RTL
=======================

// Module: button_conditioner
// PURPOSE
//   Front end for the seven game buttons ahead of encoder7to3 / state_transition.
//   Synchronises, debounces and edge-detects the raw push-buttons; adds auto-repeat on held direction keys.
//   Hands each press to the game logic as a one-hot event through a valid/ack handshake,
//   so a slow consumer cannot miss or double-count a press.
//   Bit order matches the existing bundle: {blue_reset, red_reset, decision, up, down, left, right}.
// PARAMETERS
//   N_BTN          7            number of buttons
//   DEBOUNCE_CYC   1_000_000    stable cycles required to accept a level change (10 ms at 100 MHz)
//   REPEAT_MASK    7'b0001111   buttons that auto-repeat while held (direction keys)
//   REPEAT_DELAY   50_000_000   held cycles after accepted press before first repeat
//   REPEAT_PERIOD  20_000_000   cycles between subsequent repeats
//   CNT_W          27           counter width; must hold max(DEBOUNCE_CYC, REPEAT_DELAY, REPEAT_PERIOD)
// PORTS
//   clk          in   1      system clock
//   reset_n      in   1      asynchronous active-low reset
//   btn_raw      in   N_BTN  raw button levels, 1 = pressed, asynchronous to clk
//   btn_level    out  N_BTN  debounced button levels
//   evt_valid    out  1      one event pending in evt_code
//   evt_code     out  N_BTN  one-hot pressed button; all-zero whenever evt_valid=0
//   evt_ack      in   1      consumer accepts the pending event
//   evt_dropped  out  1      1-cycle pulse: a press was discarded
// BEHAVIOUR
//   - Reset (async, reset_n=0): sync flops, btn_level, all counters, evt_valid, evt_code and evt_dropped go to 0.
//   - Synchroniser: 2-flop per bit. Debounce and edge logic use only the second flop.
//   - Debounce, per bit:
//       sync==btn_level: counter cleared.
//       otherwise: counter increments.
//       When counter reaches DEBOUNCE_CYC-1 with sync still differing: btn_level<=sync, counter cleared.
//       Any bounce back clears the counter.
//       Latency from a clean raw edge to btn_level: DEBOUNCE_CYC+2 cycles.
//   - Press pulse (internal, 1 cycle) on btn_level 0->1. No event on release.
//   - Auto-repeat, REPEAT_MASK bits only:
//       Hold counter runs while btn_level=1 and clears on release.
//       First repeat pulse REPEAT_DELAY cycles after the press pulse; then every REPEAT_PERIOD cycles.
//       Non-masked bits never repeat.
//   - Arbitration: if several press pulses occur in one cycle, the highest index wins
//     (resets > decision > up > down > left > right). Losers are discarded and evt_dropped pulses.
//   - Handshake, one-deep event register:
//       Slot free (evt_valid=0), or evt_valid=1 with evt_ack=1 this cycle: a winning press loads next cycle
//       (evt_valid=1, evt_code=one-hot). Ack plus a same-cycle press keeps valid=1 with the new code.
//       evt_valid=1 and evt_ack=0: any press is discarded and evt_dropped pulses; evt_code is held unchanged.
//       evt_ack with no new press: evt_valid=0 and evt_code=0 next cycle.
//       evt_ack while evt_valid=0 is ignored.
//   - Latency: press pulse to evt_valid = 1 cycle. Raw edge to evt_valid = DEBOUNCE_CYC+3 cycles.
//   - Button held through reset release: btn_level starts at 0, so the held button is accepted after debounce
//     and produces one press event. This is intended.
//   - Counters saturate logic-wise. They never wrap, because each clears on reaching its terminal count.
// TESTING (bench parameters DEBOUNCE_CYC=4, REPEAT_DELAY=20, REPEAT_PERIOD=8; evt_ack tied low unless stated)
//   1. Clean press:
//      btn_raw[0] 0->1 at cycle 0 -> btn_level[0]=1 at cycle 6; evt_valid=1, evt_code=7'b0000001 at cycle 7.
//   2. Bounce:
//      btn_raw[4] toggles 1,0,1 with 2-cycle spacing, then stays 1 -> exactly one event, evt_code=7'b0010000.
//      btn_level[4] rises 6 cycles after the last edge.
//   3. Simultaneous press:
//      bits 6 and 3 rise in the same cycle -> evt_code=7'b1000000 and one evt_dropped pulse in the load cycle.
//   4. Auto-repeat, evt_ack held high:
//      hold bit 1 for 60 cycles -> events at press+1, +21, +29, +37, +45, +53.
//      Repeat hold on bit 4 -> exactly one event.
//   5. Back-pressure:
//      first press loaded, no ack, second button pressed -> evt_dropped pulses, evt_code unchanged.
//      Ack -> evt_valid=0 next cycle.
//   6. Reset mid-operation:
//      assert reset_n=0 while evt_valid=1 and counters mid-count -> all outputs 0 immediately.
//      Button held across release -> one event DEBOUNCE_CYC+3 cycles after release.

Source files
------------

// File: rtl/button_conditioner_if.sv
// Event handshake between the button front end and the game logic.
//   evt_valid    one event pending in evt_code
//   evt_code     one-hot pressed button, all-zero while evt_valid=0
//   evt_ack      consumer accepts the pending event
//   evt_dropped  1-cycle pulse when a press was discarded
// master: the conditioner (producer). slave: the game logic (consumer).
interface button_conditioner_if #(
  parameter int unsigned N_BTN = 7
) ();
  logic             evt_valid;
  logic [N_BTN-1:0] evt_code;
  logic             evt_ack;
  logic             evt_dropped;

  modport master (output evt_valid, evt_code, evt_dropped, input evt_ack);
  modport slave  (input evt_valid, evt_code, evt_dropped, output evt_ack);
endinterface

// File: rtl/button_conditioner.sv
// Button front end: 2-flop sync, debounce, press detect and auto-repeat per
// button, then highest-index arbitration into a one-deep valid/ack event slot.
// Bit order: {blue_reset, red_reset, decision, up, down, left, right}.
//   clk        system clock
//   reset_n    asynchronous active-low reset
//   btn_raw    raw button levels (1 = pressed), asynchronous to clk
//   btn_level  debounced button levels
//   evt        event handshake (master side)

// Per-button lane: sync -> debounce -> registered press/repeat pulse.
//   clk, reset_n  clock / async active-low reset
//   raw           raw button level
//   level         debounced level
//   pulse         1-cycle press or auto-repeat pulse
module button_conditioner_lane #(
  parameter int unsigned DEBOUNCE_CYC  = 1_000_000,
  parameter bit          REPEAT_EN     = 1'b0,
  parameter int unsigned REPEAT_DELAY  = 50_000_000,
  parameter int unsigned REPEAT_PERIOD = 20_000_000,
  parameter int unsigned CNT_W         = 27
) (
  input  logic clk,
  input  logic reset_n,
  input  logic raw,
  output logic level,
  output logic pulse
);
  localparam logic [CNT_W-1:0] DB_LAST  = CNT_W'(DEBOUNCE_CYC - 1);
  localparam logic [CNT_W-1:0] DLY_LAST = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] PER_LAST = CNT_W'(REPEAT_PERIOD - 1);

  logic [1:0]       sync;      // sync[1] is the only flop downstream logic sees
  logic [CNT_W-1:0] db_cnt;
  logic [CNT_W-1:0] hold_cnt;
  logic             rep_phase; // 0: waiting for first repeat, 1: periodic repeats
  logic             press;
  logic             rep;
  logic             differ;
  logic             flip;
  logic [CNT_W-1:0] hold_last;

  assign differ    = sync[1] ^ level;
  assign flip      = differ && (db_cnt == DB_LAST);
  assign hold_last = rep_phase ? PER_LAST : DLY_LAST;
  assign pulse     = press | rep;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync   <= '0;
      db_cnt <= '0;
      level  <= 1'b0;
      press  <= 1'b0;
    end else begin
      sync <= {sync[0], raw};
      // Any agreement (including a bounce back) restarts the stability count.
      if (!differ || flip) db_cnt <= '0;
      else                 db_cnt <= db_cnt + CNT_W'(1);
      if (flip) level <= sync[1];
      press <= flip && !level;
    end
  end

  // Hold counter only runs while the accepted level is 1 and is not about to
  // fall, so a repeat pulse never appears in a cycle where level is 0.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hold_cnt  <= '0;
      rep_phase <= 1'b0;
      rep       <= 1'b0;
    end else if (!REPEAT_EN || !level || flip) begin
      hold_cnt  <= '0;
      rep_phase <= 1'b0;
      rep       <= 1'b0;
    end else if (hold_cnt == hold_last) begin
      hold_cnt  <= '0;
      rep_phase <= 1'b1;
      rep       <= 1'b1;
    end else begin
      hold_cnt  <= hold_cnt + CNT_W'(1);
      rep       <= 1'b0;
    end
  end
endmodule

module button_conditioner #(
  parameter int unsigned      N_BTN         = 7,
  parameter int unsigned      DEBOUNCE_CYC  = 1_000_000,
  parameter logic [N_BTN-1:0] REPEAT_MASK   = 7'b0001111,
  parameter int unsigned      REPEAT_DELAY  = 50_000_000,
  parameter int unsigned      REPEAT_PERIOD = 20_000_000,
  parameter int unsigned      CNT_W         = 27
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [N_BTN-1:0]     btn_raw,
  output logic [N_BTN-1:0]     btn_level,
  button_conditioner_if.master evt
);
  logic [N_BTN-1:0] pulse;
  logic [N_BTN-1:0] win;
  logic             any;
  logic             multi;
  logic             valid_q;
  logic [N_BTN-1:0] code_q;
  logic             drop_q;

  for (genvar i = 0; i < N_BTN; i++) begin : g_lane
    button_conditioner_lane #(
      .DEBOUNCE_CYC  (DEBOUNCE_CYC),
      .REPEAT_EN     (REPEAT_MASK[i]),
      .REPEAT_DELAY  (REPEAT_DELAY),
      .REPEAT_PERIOD (REPEAT_PERIOD),
      .CNT_W         (CNT_W)
    ) u_lane (
      .clk     (clk),
      .reset_n (reset_n),
      .raw     (btn_raw[i]),
      .level   (btn_level[i]),
      .pulse   (pulse[i])
    );
  end

  // Highest index wins: later loop iterations overwrite earlier ones.
  always_comb begin
    win = '0;
    for (int i = 0; i < N_BTN; i++) begin
      if (pulse[i]) begin
        win    = '0;
        win[i] = 1'b1;
      end
    end
  end

  assign any   = |pulse;
  assign multi = |(pulse & (pulse - N_BTN'(1)));

  // One-deep slot. win is all-zero when nothing pulsed, so loading it on an
  // ack with no new press also clears evt_code.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_q <= 1'b0;
      code_q  <= '0;
      drop_q  <= 1'b0;
    end else if (!valid_q || evt.evt_ack) begin
      valid_q <= any;
      code_q  <= win;
      drop_q  <= multi;
    end else begin
      drop_q  <= any;
    end
  end

  assign evt.evt_valid   = valid_q;
  assign evt.evt_code    = code_q;
  assign evt.evt_dropped = drop_q;
endmodule
